// File: rtl/bg_tile_writer_if.sv
// bg_tile_writer_if: start/abort controls, byte stream handshake and tile RAM write port
interface bg_tile_writer_if #(parameter int ADDR_W = 19);
  logic start_load, start_fill, abort;
  logic [7:0] fill_value, in_data;
  logic in_valid, in_ready;
  logic wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0] wr_data;
  logic busy, done;
  modport master (
    output start_load, start_fill, abort, fill_value, in_data, in_valid,
    input in_ready, wr_en, wr_addr, wr_data, busy, done
  );
  modport slave (
    input start_load, start_fill, abort, fill_value, in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/bg_tile_writer.sv
// bg_tile_writer: rewrites the background tile RAM from a byte stream (LOAD) or a constant index (FILL),
// using the reader's linear address x + y*TILE_W.
module bg_tile_writer #(
  parameter int TILE_W = 96,
  parameter int TILE_H = 32,
  parameter int ADDR_W = 19
) (
  input logic Clk,
  input logic Reset_n,
  bg_tile_writer_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0, S_LOAD = 2'd1, S_FILL = 2'd2;
  localparam int XW = $clog2(TILE_W + 1);
  localparam int YW = $clog2(TILE_H + 1);
  logic [1:0] r_state;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [7:0] r_fill, r_wr_data;
  logic [ADDR_W-1:0] r_wr_addr;
  logic r_wr_en, r_done;
  logic w_write, w_x_end, w_last, w_start;
  logic [ADDR_W-1:0] w_addr;
  assign w_write = !bus.abort && (r_state == S_FILL || (r_state == S_LOAD && bus.in_valid));
  assign w_x_end = r_x == XW'(TILE_W - 1);
  assign w_last = w_x_end && r_y == YW'(TILE_H - 1);
  assign w_start = !bus.abort && (bus.start_fill || bus.start_load);
  assign w_addr = ADDR_W'(r_x) + ADDR_W'(r_y) * ADDR_W'(TILE_W);
  assign bus.in_ready = r_state == S_LOAD && !bus.abort;
  assign bus.busy = r_state != S_IDLE;
  assign bus.done = r_done;
  assign bus.wr_en = r_wr_en;
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_data = r_wr_data;
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
      r_x <= '0;
      r_y <= '0;
      r_fill <= '0;
      r_wr_en <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_done <= 1'b0;
    end else begin
      r_wr_en <= w_write;
      if (w_write) begin
        r_wr_addr <= w_addr;
        r_wr_data <= r_state == S_FILL ? r_fill : bus.in_data;
      end
      if (r_state == S_IDLE) begin
        if (w_start) begin
          r_state <= bus.start_fill ? S_FILL : S_LOAD;
          r_done <= 1'b0;
          r_x <= '0;
          r_y <= '0;
          if (bus.start_fill) r_fill <= bus.fill_value;
        end
      end else if (bus.abort) begin
        r_state <= S_IDLE;
        r_x <= '0;
        r_y <= '0;
      end else if (w_write) begin
        // last entry returns to IDLE with done set on the same edge
        if (w_last) begin
          r_state <= S_IDLE;
          r_x <= '0;
          r_y <= '0;
          r_done <= 1'b1;
        end else if (w_x_end) begin
          r_x <= '0;
          r_y <= r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/bg_tile_writer.md
Name: bg_tile_writer

Overview:
- Write-side counterpart of the background tile ROM reader: fills the background wall tile RAM (TILE_W x TILE_H bytes of palette indices).
- Two modes: LOAD accepts a byte stream over a valid/ready handshake, for example from a loader or UART path; FILL writes one constant palette index to every entry.
- Generates the same linear address the reader computes (x + y*TILE_W), so the reader-side tile RAM can be rewritten at runtime without a rebuild.

Parameters:
TILE_W, 96, tile width in pixels
TILE_H, 32, tile height in pixels
ADDR_W, 19, write address width; matches reader address width

Ports:
Clk  input  1  system clock, all logic on rising edge
Reset_n  input  1  asynchronous active-low reset
start_load  input  1  one-cycle request to begin stream load
start_fill  input  1  one-cycle request to begin constant fill
abort  input  1  synchronous cancel of any active operation
fill_value  input  8  palette index used by FILL, sampled at start
in_data  input  8  stream byte
in_valid  input  1  stream byte valid
in_ready  output  1  writer accepts stream byte this cycle
wr_en  output  1  RAM write strobe, registered
wr_addr  output  ADDR_W  RAM write address, registered
wr_data  output  8  RAM write data, registered
busy  output  1  operation in progress
done  output  1  sticky, last operation completed fully

Behaviour:
- Reset (async, Reset_n=0), all cleared immediately:
  - state=IDLE; x=0, y=0.
  - wr_en=0, wr_addr=0, wr_data=0.
  - in_ready=0, busy=0, done=0.
- States are IDLE, LOAD and FILL. busy=1 in LOAD and FILL. in_ready = (state==LOAD) && !abort, combinational.
- IDLE:
  - start_fill=1 -> FILL; latch fill_value into fill_reg.
  - start_load=1 with start_fill=0 -> LOAD.
  - start_fill and start_load both 1 -> FILL wins.
  - Any start clears done and sets x=y=0.
- Start pulses in LOAD or FILL are ignored; latched fill_reg does not change.
- Address generation:
  - Counters: x in 0..TILE_W-1, y in 0..TILE_H-1.
  - Address = x + y*TILE_W, computed in ADDR_W bits, no truncation for the default parameters (max 3071).
- Write latency: one cycle. A beat accepted at edge N appears on wr_en/wr_addr/wr_data during the cycle after edge N. wr_en is 1 for exactly one cycle per write.
- LOAD:
  - A beat is accepted when in_valid && in_ready. Then wr_data <= in_data, wr_addr <= current address, wr_en <= 1.
  - Counter advance: x increments; at x=TILE_W-1, x wraps to 0 and y increments.
  - in_valid=0: no write; wr_en=0 next cycle; counters hold.
- FILL: one write per cycle with wr_data=fill_reg, no handshake. Takes exactly TILE_W*TILE_H cycles.
- Completion:
  - The write at x=TILE_W-1, y=TILE_H-1 is the last one. Next state is IDLE, counters return to 0, and done <= 1 on the same edge.
  - busy falls on the same edge. in_ready is 0 from that edge onward.
- abort=1 in LOAD or FILL:
  - No write is issued for that cycle; a beat presented that cycle is not accepted.
  - state -> IDLE, counters reset, done stays 0.
  - Entries already written are not restored.
- abort in IDLE has no effect. abort with a start in the same IDLE cycle: abort wins and no operation starts.
- in_valid outside LOAD is ignored; no counter or output change.
- Reset mid-operation: outputs clear asynchronously. No further writes; partial RAM contents are left as written.
- wr_addr and wr_data hold their last value when wr_en=0.

Test Plan:
- Reset, then start_fill with fill_value=0x04 -> 3072 consecutive wr_en cycles; wr_addr 0..3071 with data 0x04; busy falls and done=1 after the last write; in_ready stays 0 throughout.
- start_load, stream bytes 0x00,0x01,... with in_valid toggling every other cycle -> writes only on accepted beats; wr_addr 95 then 96 across the x wrap with data equal to the low byte of the address; done=1 after beat 3072.
- LOAD, abort asserted together with in_valid at beat 500 -> that beat not written; busy=0 next cycle, done=0; a new start_load writes address 0 first.
- start_load and start_fill in the same cycle with fill_value=0x2A -> FILL entered, all data 0x2A; start_load pulse at cycle 100 ignored; fill_value change mid-fill has no effect.
- Reset_n low during FILL at write 1000 -> wr_en, busy and done are 0 immediately, with no clock edge needed; after release, IDLE with no writes until a start.
- After done=1, start_load -> done clears on the start edge and busy=1; in_valid held 0 -> no writes, in_ready=1 steady.
